// File: rtl/obstacle_control.sv
// obstacle_control
// ----------------
// Control FSM for a sprite that moves across a VGA screen. Each pass draws
// the object, holds it for a number of frame ticks, erases it, and then
// steps it one pixel. If the datapath reports that the object is past its
// end column at the moment the hold expires, the game is over.
//
// Parameters
//   FRAME_DIV       clock cycles per frame tick
//   FRAMES_PER_STEP frame ticks per one-pixel move
//   OBJ_PIXELS      pixels written per draw/erase pass
//
// Ports
//   clock       system clock, rising edge
//   resetn      asynchronous active-low reset
//   start       asynchronous push-button level (synchronised internally)
//   finish      datapath flag: object past its end column
//   draw        datapath pixel-counter advance enable
//   erase       colour select, 1 = background colour 0
//   plot        VGA adapter write enable
//   setoff      high while holding a drawn frame
//   step        one-cycle pulse advancing object x by one
//   frame_tick  one-cycle pulse every FRAME_DIV cycles while holding
//   game_over   high in OVER
//   state       current FSM encoding (debug)
module obstacle_control #(
  parameter int FRAME_DIV       = 833333,
  parameter int FRAMES_PER_STEP = 4,
  parameter int OBJ_PIXELS      = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       finish,
  output logic       draw,
  output logic       erase,
  output logic       plot,
  output logic       setoff,
  output logic       step,
  output logic       frame_tick,
  output logic       game_over,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAW  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_ERASE = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  // Counter widths: ceil(log2(N)), never below one bit.
  localparam int PW = (OBJ_PIXELS > 1)      ? $clog2(OBJ_PIXELS)      : 1;
  localparam int CW = (FRAME_DIV > 1)       ? $clog2(FRAME_DIV)       : 1;
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [PW-1:0] PIX_LAST   = PW'(OBJ_PIXELS - 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'(FRAME_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

  logic [2:0]    state_reg, state_next;
  logic [1:0]    sync_reg;
  logic          start_prev_reg;
  logic          start_edge;
  logic [PW-1:0] pix_reg, pix_next;
  logic [CW-1:0] cyc_reg, cyc_next;
  logic [FW-1:0] frame_reg, frame_next;
  logic          pix_last;
  logic          cyc_last;
  logic          hold_done;

  // ---------------------------------------------------------------------
  // Start synchroniser and rising-edge detector. The edge is seen one
  // cycle after the second flop goes high, so the FSM reacts on the third
  // clock edge after start is first sampled.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_reg       <= 2'b00;
      start_prev_reg <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[0], start};
      start_prev_reg <= sync_reg[1];
    end
  end

  assign start_edge = sync_reg[1] & ~start_prev_reg;

  assign pix_last  = (pix_reg == PIX_LAST);
  assign cyc_last  = (cyc_reg == CYC_LAST);
  // The hold ends on the tick that completes the last frame of the step.
  assign hold_done = (state_reg == S_HOLD) && cyc_last && (frame_reg == FRAME_LAST);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic. Start edges outside IDLE/OVER fall through
  // unused, so they are discarded rather than queued. finish only matters
  // on the single cycle the hold expires.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_edge) state_next = S_DRAW;
      S_DRAW:  if (pix_last)   state_next = S_HOLD;
      S_HOLD:  if (hold_done)  state_next = finish ? S_OVER : S_ERASE;
      S_ERASE: if (pix_last)   state_next = S_STEP;
      S_STEP:  state_next = S_DRAW;
      S_OVER:  if (start_edge) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (Moore, so an asynchronous reset silences them at once)
  // ---------------------------------------------------------------------
  always_comb begin
    draw       = 1'b0;
    erase      = 1'b0;
    plot       = 1'b0;
    setoff     = 1'b0;
    step       = 1'b0;
    frame_tick = 1'b0;
    game_over  = 1'b0;
    case (state_reg)
      S_DRAW: begin
        draw = 1'b1;
        plot = 1'b1;
      end
      S_HOLD: begin
        setoff     = 1'b1;
        frame_tick = cyc_last;
      end
      S_ERASE: begin
        draw  = 1'b1;
        plot  = 1'b1;
        erase = 1'b1;
      end
      S_STEP:  step      = 1'b1;
      S_OVER:  game_over = 1'b1;
      default: ;
    endcase
  end

  assign state = state_reg;

  // ---------------------------------------------------------------------
  // Counters. The pixel counter runs only in DRAW/ERASE and wraps to 0 on
  // the last pixel, so it is already clear when the next pass starts; it
  // is forced to 0 elsewhere so that every pass begins at pixel 0. The
  // cycle and frame counters are cleared on every HOLD entry and frozen
  // outside HOLD.
  // ---------------------------------------------------------------------
  always_comb begin
    pix_next   = '0;
    cyc_next   = cyc_reg;
    frame_next = frame_reg;

    if (state_reg == S_DRAW || state_reg == S_ERASE) begin
      pix_next = pix_last ? '0 : pix_reg + 1'b1;
    end

    if (state_reg == S_HOLD) begin
      cyc_next = cyc_last ? '0 : cyc_reg + 1'b1;
      if (cyc_last) begin
        frame_next = (frame_reg == FRAME_LAST) ? '0 : frame_reg + 1'b1;
      end
    end else if (state_next == S_HOLD) begin
      cyc_next   = '0;
      frame_next = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_reg   <= '0;
      cyc_reg   <= '0;
      frame_reg <= '0;
    end else begin
      pix_reg   <= pix_next;
      cyc_reg   <= cyc_next;
      frame_reg <= frame_next;
    end
  end

endmodule

// File: tb/tb_obstacle_control.sv
// Directed testbench for obstacle_control with FRAME_DIV=4,
// FRAMES_PER_STEP=2, OBJ_PIXELS=16. Inputs are driven and outputs sampled
// 1 ns after each rising clock edge.
module tb_obstacle_control;

  logic       clock;
  logic       resetn;
  logic       start;
  logic       finish;
  logic       draw;
  logic       erase;
  logic       plot;
  logic       setoff;
  logic       step;
  logic       frame_tick;
  logic       game_over;
  logic [2:0] state;

  int n_cmp;
  int n_err;

  obstacle_control #(
    .FRAME_DIV       (4),
    .FRAMES_PER_STEP (2),
    .OBJ_PIXELS      (16)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .finish     (finish),
    .draw       (draw),
    .erase      (erase),
    .plot       (plot),
    .setoff     (setoff),
    .step       (step),
    .frame_tick (frame_tick),
    .game_over  (game_over),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    start  = 1'b0;
    finish = 1'b0;
    resetn = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got %0d expected 0", state);
    end
    n_cmp++;
    if ({draw, erase, plot, setoff, step, frame_tick, game_over} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {draw, erase, plot, setoff, step, frame_tick, game_over});
    end
    resetn = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (state !== 3'd0 || plot !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_release: state %0d plot %b expected 0 0", state, plot);
    end
    $display("test_reset done");
  endtask

  // Start pulse -> DRAW on third edge, 16 plot cycles, then HOLD.
  task automatic test_start_to_draw();
    int cnt;
    int bad;
    start = 1'b1;
    tick();           // edge 1
    start = 1'b0;
    tick();           // edge 2
    n_cmp++;
    if (state !== 3'd0) begin
      n_err++;
      $display("FAIL draw_not_early: state %0d expected 0", state);
    end
    tick();           // edge 3
    n_cmp++;
    if (state !== 3'd1) begin
      n_err++;
      $display("FAIL draw_on_3rd_edge: state %0d expected 1", state);
    end
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (state !== 3'd1) break;
      if (!(draw === 1'b1 && plot === 1'b1 && erase === 1'b0)) bad++;
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 16 || bad !== 0) begin
      n_err++;
      $display("FAIL draw_len: cycles %0d bad %0d expected 16 0", cnt, bad);
    end
    n_cmp++;
    if (state !== 3'd2 || setoff !== 1'b1 || plot !== 1'b0) begin
      n_err++;
      $display("FAIL enter_hold: state %0d setoff %b plot %b expected 2 1 0",
               state, setoff, plot);
    end
    $display("test_start_to_draw done");
  endtask

  // HOLD (finish=0) -> ticks at HOLD cycles 3 and 7, ERASE, STEP, DRAW.
  task automatic test_hold_erase_step();
    int h;
    int nt;
    int t0;
    int t1;
    int cnt;
    int bad;
    finish = 1'b0;
    h = 0; nt = 0; t0 = -1; t1 = -1;
    for (int i = 0; i < 20; i++) begin
      if (state !== 3'd2) break;
      if (frame_tick === 1'b1) begin
        if (nt == 0) t0 = h;
        else t1 = h;
        nt++;
      end
      h++;
      tick();
    end
    n_cmp++;
    if (h !== 8) begin
      n_err++;
      $display("FAIL hold_len: got %0d expected 8", h);
    end
    n_cmp++;
    if (nt !== 2 || t0 !== 3 || t1 !== 7) begin
      n_err++;
      $display("FAIL frame_ticks: count %0d at %0d,%0d expected 2 at 3,7", nt, t0, t1);
    end
    n_cmp++;
    if (state !== 3'd3) begin
      n_err++;
      $display("FAIL enter_erase: state %0d expected 3", state);
    end
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (state !== 3'd3) break;
      if (!(draw === 1'b1 && plot === 1'b1 && erase === 1'b1)) bad++;
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 16 || bad !== 0) begin
      n_err++;
      $display("FAIL erase_len: cycles %0d bad %0d expected 16 0", cnt, bad);
    end
    n_cmp++;
    if (state !== 3'd4 || step !== 1'b1 || plot !== 1'b0) begin
      n_err++;
      $display("FAIL step_pulse: state %0d step %b plot %b expected 4 1 0",
               state, step, plot);
    end
    tick();
    n_cmp++;
    if (state !== 3'd1 || step !== 1'b0) begin
      n_err++;
      $display("FAIL step_to_draw: state %0d step %b expected 1 0", state, step);
    end
    $display("test_hold_erase_step done");
  endtask

  // From DRAW or later, run until HOLD is reached (bounded).
  task automatic test_finish();
    int h;
    for (int i = 0; i < 80; i++) begin
      if (state === 3'd2) break;
      tick();
    end
    n_cmp++;
    if (state !== 3'd2) begin
      n_err++;
      $display("FAIL reach_hold_1: state %0d expected 2", state);
    end
    // finish high everywhere except the exit cycle -> ERASE
    h = 0;
    for (int i = 0; i < 20; i++) begin
      if (state !== 3'd2) break;
      finish = (h != 7);
      h++;
      tick();
    end
    finish = 1'b0;
    n_cmp++;
    if (state !== 3'd3) begin
      n_err++;
      $display("FAIL finish_ignored: state %0d expected 3", state);
    end
    for (int i = 0; i < 80; i++) begin
      if (state === 3'd2) break;
      tick();
    end
    n_cmp++;
    if (state !== 3'd2) begin
      n_err++;
      $display("FAIL reach_hold_2: state %0d expected 2", state);
    end
    // finish high only on the exit cycle -> OVER
    h = 0;
    for (int i = 0; i < 20; i++) begin
      if (state !== 3'd2) break;
      finish = (h == 7);
      h++;
      tick();
    end
    finish = 1'b0;
    n_cmp++;
    if (state !== 3'd5 || game_over !== 1'b1) begin
      n_err++;
      $display("FAIL enter_over: state %0d game_over %b expected 5 1", state, game_over);
    end
    n_cmp++;
    if ({draw, erase, plot, setoff, step, frame_tick} !== 6'b0) begin
      n_err++;
      $display("FAIL over_outputs: got %b expected 000000",
               {draw, erase, plot, setoff, step, frame_tick});
    end
    finish = 1'b1;
    tick();
    tick();
    tick();
    finish = 1'b0;
    n_cmp++;
    if (state !== 3'd5) begin
      n_err++;
      $display("FAIL over_stays: state %0d expected 5", state);
    end
    $display("test_finish done");
  endtask

  // OVER + start edge -> IDLE; second start edge -> DRAW.
  task automatic test_over_restart();
    pulse_start();
    tick();
    tick();
    n_cmp++;
    if (state !== 3'd0 || game_over !== 1'b0) begin
      n_err++;
      $display("FAIL over_to_idle: state %0d game_over %b expected 0 0", state, game_over);
    end
    pulse_start();
    tick();
    tick();
    n_cmp++;
    if (state !== 3'd1 || plot !== 1'b1) begin
      n_err++;
      $display("FAIL restart_draw: state %0d plot %b expected 1 1", state, plot);
    end
    $display("test_over_restart done");
  endtask

  // Start edges during HOLD leave the hold length and exit untouched.
  task automatic test_start_in_hold();
    int h;
    for (int i = 0; i < 80; i++) begin
      if (state === 3'd2) break;
      tick();
    end
    h = 0;
    for (int i = 0; i < 20; i++) begin
      if (state !== 3'd2) break;
      start = (h % 2 == 0);
      h++;
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if (h !== 8 || state !== 3'd3) begin
      n_err++;
      $display("FAIL start_in_hold: hold %0d state %0d expected 8 3", h, state);
    end
    $display("test_start_in_hold done");
  endtask

  // Start held high for 100 cycles -> exactly one IDLE->DRAW entry.
  task automatic test_start_held();
    int entries;
    logic [2:0] prev;
    do_reset();
    prev = state;
    entries = 0;
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (prev === 3'd0 && state === 3'd1) entries++;
      prev = state;
    end
    start = 1'b0;
    n_cmp++;
    if (entries !== 1) begin
      n_err++;
      $display("FAIL start_held: idle_to_draw %0d expected 1", entries);
    end
    do_reset();
    $display("test_start_held done");
  endtask

  // Asynchronous reset at DRAW cycle 7, then 50 idle cycles with no start.
  task automatic test_reset_mid_draw();
    int bad;
    pulse_start();
    tick();
    tick();       // DRAW cycle 1
    for (int i = 0; i < 6; i++) tick();   // DRAW cycle 7
    n_cmp++;
    if (state !== 3'd1) begin
      n_err++;
      $display("FAIL pre_reset_draw: state %0d expected 1", state);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (plot !== 1'b0 || state !== 3'd0 || draw !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: plot %b state %0d draw %b expected 0 0 0",
               plot, state, draw);
    end
    tick();
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (state !== 3'd0 || plot !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL idle_after_reset: non-idle cycles %0d expected 0", bad);
    end
    $display("test_reset_mid_draw done");
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    resetn = 1'b0;
    start  = 1'b0;
    finish = 1'b0;
    test_reset();
    test_start_to_draw();
    test_hold_erase_step();
    test_finish();
    test_over_restart();
    test_start_in_hold();
    test_start_held();
    test_reset_mid_draw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/obstacle_control.md
OBSTACLE_CONTROL -- requirements
Module: obstacle_control

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 833333, meaning clock cycles per frame tick (1/60 s at 50 MHz).
REQ-002 SHALL have parameter FRAMES_PER_STEP, default 4, meaning frame ticks per one-pixel object move.
REQ-003 SHALL have parameter OBJ_PIXELS, default 16, meaning pixels per object draw/erase pass (4x4 sprite).
REQ-004 SHALL have port clock, input, 1, system clock; all state updates on rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, asynchronous push-button level, active-high.
REQ-007 SHALL have port finish, input, 1, datapath flag meaning the object is past its end column.
REQ-008 SHALL have port draw, output, 1, datapath pixel-counter advance enable.
REQ-009 SHALL have port erase, output, 1, datapath colour select (1 = background colour 0).
REQ-010 SHALL have port plot, output, 1, VGA adapter write enable for the current x/y/colour.
REQ-011 SHALL have port setoff, output, 1, high while holding a drawn frame.
REQ-012 SHALL have port step, output, 1, one-cycle pulse advancing object x by one.
REQ-013 SHALL have port frame_tick, output, 1, one-cycle pulse every FRAME_DIV cycles in HOLD.
REQ-014 SHALL have port game_over, output, 1, high in OVER.
REQ-015 SHALL have port state, output, 3, current FSM encoding for debug.

Function
REQ-016 SHALL pass start through a two-flop synchroniser, then a rising-edge detector; only the detected edge is used.
REQ-017 SHALL implement states IDLE=0, DRAW=1, HOLD=2, ERASE=3, STEP=4, OVER=5; codes 6-7 SHALL go to IDLE next cycle.
REQ-018 In IDLE, all control outputs SHALL be 0; a start edge SHALL move to DRAW, clearing the pixel counter.
REQ-019 The first cycle with state==DRAW SHALL be the 3rd rising edge after start is first sampled high.
REQ-020 In DRAW, draw=plot=1, erase=0 every cycle; the pixel counter increments each cycle.
REQ-021 DRAW SHALL last exactly OBJ_PIXELS cycles, then go to HOLD; the pixel counter SHALL wrap to 0.
REQ-022 In HOLD, setoff=1; the cycle counter counts 0..FRAME_DIV-1 and pulses frame_tick for one cycle at FRAME_DIV-1, then wraps.
REQ-023 The frame counter SHALL increment on each frame_tick; on the FRAMES_PER_STEP-th tick the FSM SHALL leave HOLD.
REQ-024 On leaving HOLD, finish SHALL be sampled in that same cycle: 1 -> OVER, 0 -> ERASE.
REQ-025 finish SHALL be ignored in all other cycles.
REQ-026 Cycle and frame counters SHALL be cleared on every HOLD entry and SHALL hold outside HOLD.
REQ-027 In ERASE, draw=plot=erase=1 for exactly OBJ_PIXELS cycles, then go to STEP.
REQ-028 STEP SHALL last one cycle with step=1, then go to DRAW.
REQ-029 In OVER, game_over=1 and all other outputs 0; a start edge SHALL return to IDLE.
REQ-030 Start edges in DRAW, HOLD, ERASE and STEP SHALL be discarded, not queued.
REQ-031 Counter widths SHALL be ceil(log2(parameter)) with a minimum of 1; no arithmetic overflow is permitted.

Reset
REQ-032 On resetn low, regardless of clock: state=IDLE; all outputs, counters and synchroniser flops = 0.
REQ-033 Reset mid-DRAW, HOLD or ERASE SHALL abort the pass with no further plot; after release, the FSM waits in IDLE for a new start edge.

Verification (FRAME_DIV=4, FRAMES_PER_STEP=2, OBJ_PIXELS=16)
REQ-034 Start pulse from IDLE -> DRAW on the 3rd edge; plot=1 for exactly 16 cycles; then HOLD.
REQ-035 HOLD with finish=0 -> frame_tick pulses 4 cycles apart; ERASE entered after 8 HOLD cycles; 16 erase=1 plot cycles; one step pulse; DRAW again.
REQ-036 finish=1 throughout HOLD except the exit cycle -> ERASE; finish=1 on the exit cycle -> OVER, game_over=1, no plot.
REQ-037 Start held high for 100 cycles from IDLE -> exactly one DRAW pass begins; start edges during HOLD -> no effect.
REQ-038 resetn low at DRAW cycle 7 -> plot=0 immediately, state=0; after release with no start, state stays 0 for 50 cycles.
REQ-039 OVER plus a start edge -> IDLE, game_over=0; a second start edge -> DRAW.
